// File: rtl/accum_vector_player.sv
// Vector player/checker for the registered add/sub accumulator:
// streams stored vectors one per clock and counts Z/Overflow mismatches.
module accum_vector_player #(
    parameter int N      = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int LAT    = 1,
    parameter int ERR_W  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Wr_En,
    input  logic [ADDR_W-1:0] Wr_Addr,
    input  logic [3*N+3:0]    Wr_Data,
    input  logic [ADDR_W:0]   Num_Vec,
    input  logic              Start,
    output logic [N-1:0]      A,
    output logic [N-1:0]      B,
    output logic              Sel,
    output logic              AddSub,
    output logic              Dut_Reset,
    input  logic [N-1:0]      Z,
    input  logic              Overflow,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [ERR_W-1:0]  Err_Count,
    output logic [ADDR_W-1:0] First_Fail
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [ADDR_W:0]  DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]  ONE_A   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ONE_E   = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t            state_q, state_d;
    logic [3*N+3:0]    mem_q [DEPTH];
    logic [ADDR_W:0]   m_q, m_d, rd_q, rd_d;
    logic [N-1:0]      a_q, a_d, b_q, b_d;
    logic              sel_q, sel_d, as_q, as_d, drst_q, drst_d;
    logic              busy_q, done_q, pass_q;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] ff_q, ff_d;

    logic              pv_q [LAT+1];
    logic [N-1:0]      pz_q [LAT+1];
    logic              po_q [LAT+1];
    logic [ADDR_W-1:0] pi_q [LAT+1];

    logic              push_v, idle_w, busy_w, wr_ok, mism, last_chk;
    logic [ADDR_W:0]   num_clamp;
    logic [ADDR_W-1:0] ld_idx;
    logic [3*N+3:0]    vec;

    assign idle_w    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy_w    = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign wr_ok     = idle_w && Wr_En && ({1'b0, Wr_Addr} < DEPTH_C);
    assign num_clamp = (Num_Vec > DEPTH_C) ? DEPTH_C : Num_Vec;
    assign ld_idx    = idle_w ? '0 : rd_q[ADDR_W-1:0];

    // Forward a same-edge write so Start+Wr_En plays the fresh slot 0
    assign vec = (wr_ok && (Wr_Addr == ld_idx)) ? Wr_Data : mem_q[ld_idx];

    assign mism = busy_w && pv_q[LAT] &&
                  ((Z != pz_q[LAT]) || (Overflow != po_q[LAT]));
    assign last_chk = busy_w && pv_q[LAT] &&
                      ({1'b0, pi_q[LAT]} == (m_q - ONE_A));

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        rd_d    = rd_q;
        a_d     = '0;
        b_d     = '0;
        sel_d   = 1'b0;
        as_d    = 1'b0;
        drst_d  = 1'b1;
        push_v  = 1'b0;
        err_d   = err_q;
        ff_d    = ff_q;
        if (mism) begin
            if (err_q != ERR_MAX) err_d = err_q + ONE_E;
            if (err_q == '0) ff_d = pi_q[LAT];
        end
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    err_d = '0;
                    ff_d  = '0;
                    m_d   = num_clamp;
                    rd_d  = ONE_A;
                    if (num_clamp == '0) begin
                        state_d = S_DONE;
                    end else begin
                        push_v  = 1'b1;
                        state_d = (num_clamp == ONE_A) ? S_FLUSH : S_RUN;
                    end
                end
            end
            S_RUN: begin
                push_v = 1'b1;
                rd_d   = rd_q + ONE_A;
                if (rd_q == (m_q - ONE_A)) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                drst_d = 1'b0;
                if (last_chk) state_d = S_DONE;
            end
            default: ;
        endcase
        if (push_v) begin
            {a_d, b_d, sel_d, as_d, drst_d} = vec[3*N+3:N+1];
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_ok) mem_q[Wr_Addr] <= Wr_Data;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            as_q    <= 1'b0;
            drst_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
            for (int i = 0; i <= LAT; i++) begin
                pv_q[i] <= 1'b0;
                pz_q[i] <= '0;
                po_q[i] <= 1'b0;
                pi_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            as_q    <= as_d;
            drst_q  <= drst_d;
            busy_q  <= (state_d == S_RUN) || (state_d == S_FLUSH);
            done_q  <= (state_d == S_DONE);
            pass_q  <= (state_d == S_DONE) && (err_d == '0);
            err_q   <= err_d;
            ff_q    <= ff_d;
            pv_q[0] <= push_v;
            pz_q[0] <= vec[N:1];
            po_q[0] <= vec[0];
            pi_q[0] <= ld_idx;
            for (int i = 1; i <= LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pz_q[i] <= pz_q[i-1];
                po_q[i] <= po_q[i-1];
                pi_q[i] <= pi_q[i-1];
            end
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign Sel        = sel_q;
    assign AddSub     = as_q;
    assign Dut_Reset  = drst_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Pass       = pass_q;
    assign Err_Count  = err_q;
    assign First_Fail = ff_q;
endmodule

// File: tb/tb_accum_vector_player.sv
// Bench for accum_vector_player: a behavioural accumulator closes the loop,
// a second instance (ERR_W=2) sees inverted Z to exercise saturation.
module tb_accum_vector_player;
    localparam int N      = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int LAT    = 1;
    localparam int ERR_W  = 8;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sel;
        logic         sub;
        logic         rst;
        logic [N-1:0] zx;
        logic         ox;
    } vec_t;

    typedef struct {
        int         nv;
        logic [7:0] bad;
        bit         wr0;
        int         m;
        int         err;
        int         ff;
        bit         pass;
        int         err2;
    } run_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              wr_en, start;
    logic [ADDR_W-1:0] wr_addr;
    logic [3*N+3:0]    wr_data;
    logic [ADDR_W:0]   num_vec;
    logic [N-1:0]      a, b, z, zinv, a2, b2;
    logic              sel, addsub, drst, ovf, busy, done, pass;
    logic              sel2, as2, drst2, busy2, done2, pass2;
    logic [ERR_W-1:0]  err;
    logic [1:0]        err2;
    logic [ADDR_W-1:0] ff, ff2;

    vec_t        vt [8];
    run_t        rt [8];
    logic [34:0] sb [$];
    int          checks = 0;
    int          failures = 0;

    accum_vector_player #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                          .LAT(LAT), .ERR_W(ERR_W)) u_dut (
        .Clock(clk), .Reset(rst), .Wr_En(wr_en), .Wr_Addr(wr_addr),
        .Wr_Data(wr_data), .Num_Vec(num_vec), .Start(start),
        .A(a), .B(b), .Sel(sel), .AddSub(addsub), .Dut_Reset(drst),
        .Z(z), .Overflow(ovf), .Busy(busy), .Done(done), .Pass(pass),
        .Err_Count(err), .First_Fail(ff)
    );

    accum_vector_player #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                          .LAT(LAT), .ERR_W(2)) u_sat (
        .Clock(clk), .Reset(rst), .Wr_En(wr_en), .Wr_Addr(wr_addr),
        .Wr_Data(wr_data), .Num_Vec(num_vec), .Start(start),
        .A(a2), .B(b2), .Sel(sel2), .AddSub(as2), .Dut_Reset(drst2),
        .Z(zinv), .Overflow(ovf), .Busy(busy2), .Done(done2), .Pass(pass2),
        .Err_Count(err2), .First_Fail(ff2)
    );

    // Accumulator: Sel=0 -> A op B, Sel=1 -> Z op B; AddSub=1 subtracts
    logic [N-1:0] opa;
    logic [N:0]   sum;
    assign zinv = ~z;
    always_comb begin
        opa = sel ? z : a;
        sum = addsub ? ({1'b0, opa} - {1'b0, b}) : ({1'b0, opa} + {1'b0, b});
    end
    always @(posedge clk) begin
        if (drst) begin
            z   <= '0;
            ovf <= 1'b0;
        end else begin
            z   <= sum[N-1:0];
            ovf <= (addsub ? (opa[N-1] != b[N-1]) : (opa[N-1] == b[N-1]))
                   && (sum[N-1] != opa[N-1]);
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] bad);
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v = vt[i];
            if (bad[i]) v.zx = v.zx + 16'd1;
            wr_en   = 1'b1;
            wr_addr = i[ADDR_W-1:0];
            wr_data = v;
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic run(input int r, input bit intf);
        int tdone, nb, exp_t;
        logic [34:0] e;
        sb.delete();
        load(rt[r].bad);
        num_vec = rt[r].nv[ADDR_W:0];
        start   = 1'b1;
        if (rt[r].wr0) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = vt[0];
        end
        for (int k = 0; k < rt[r].m; k++)
            sb.push_back({vt[k].a, vt[k].b, vt[k].sel, vt[k].sub, vt[k].rst});
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        nb    = 0;
        tdone = -1;
        for (int t = 0; t < 40; t++) begin
            if (intf && t == 2) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 3'd7;
                wr_data = '1;
            end
            if (intf && t == 3) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (t < rt[r].m) begin
                e = sb.pop_front();
                chk($sformatf("vec_out[%0d] run%0d", t, r),
                    {a, b, sel, addsub, drst}, e);
            end else if (t == rt[r].m && rt[r].m > 0) begin
                chk($sformatf("flush_out run%0d", r),
                    {a, b, sel, addsub, drst}, 35'h0);
            end
            if (busy) nb++;
            if (done) begin
                tdone = t;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        exp_t = (rt[r].m == 0) ? 0 : rt[r].m + LAT;
        chk($sformatf("done_time run%0d", r), tdone, exp_t);
        chk($sformatf("busy_cycles run%0d", r), nb, exp_t);
        chk($sformatf("pass run%0d", r), pass, rt[r].pass);
        chk($sformatf("err run%0d", r), err, rt[r].err);
        chk($sformatf("first_fail run%0d", r), ff, rt[r].ff);
        chk($sformatf("err_sat run%0d", r), err2, rt[r].err2);
        chk($sformatf("first_fail_sat run%0d", r), ff2, 0);
        chk($sformatf("pass_sat run%0d", r), pass2, rt[r].err2 == 0);
        chk($sformatf("sb_empty run%0d", r), sb.size(), 0);
        if (rt[r].m == 0) chk("dut_reset_m0", drst, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        num_vec = '0;
        start   = 1'b0;
        vt[0] = '{16'd54,   16'd1850,  1'b0, 1'b0, 1'b0, 16'd1904,  1'b0};
        vt[1] = '{16'd132,  16'd63,    1'b0, 1'b1, 1'b0, 16'd69,    1'b0};
        vt[2] = '{16'd0,    16'd31,    1'b1, 1'b0, 1'b0, 16'd100,   1'b0};
        vt[3] = '{16'd0,    16'd40,    1'b1, 1'b1, 1'b0, 16'd60,    1'b0};
        vt[4] = '{16'd9,    16'd9,     1'b0, 1'b0, 1'b1, 16'd0,     1'b0};
        vt[5] = '{16'd700,  16'd70,    1'b0, 1'b1, 1'b0, 16'd630,   1'b0};
        vt[6] = '{16'd0,    16'd5,     1'b1, 1'b0, 1'b0, 16'd635,   1'b0};
        vt[7] = '{16'd7630, 16'd30000, 1'b0, 1'b0, 1'b0, 16'd37630, 1'b1};
        //        nv  bad    wr0   m  err ff pass  err2
        rt[0] = '{8,  8'h00, 1'b0, 8, 0,  0, 1'b1, 3};
        rt[1] = '{8,  8'h20, 1'b0, 8, 1,  5, 1'b0, 3};
        rt[2] = '{0,  8'h00, 1'b0, 0, 0,  0, 1'b1, 0};
        rt[3] = '{12, 8'h00, 1'b0, 8, 0,  0, 1'b1, 3};
        rt[4] = '{1,  8'h01, 1'b0, 1, 1,  0, 1'b0, 1};
        rt[5] = '{3,  8'h06, 1'b0, 3, 2,  1, 1'b0, 3};
        rt[6] = '{2,  8'h01, 1'b1, 2, 0,  0, 1'b1, 2};
        rt[7] = '{8,  8'h80, 1'b0, 8, 1,  7, 1'b0, 3};

        repeat (2) @(negedge clk);
        chk("reset_dut_out", {a, b, sel, addsub, drst}, 35'h1);
        chk("reset_status", {busy, done, pass}, 3'b000);
        chk("reset_err", err, 0);
        chk("reset_ff", ff, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) run(r, 1'b0);

        load(8'h02);
        num_vec = 4'd8;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_before_reset", err, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrun_rst_dut_out", {a, b, sel, addsub, drst}, 35'h1);
        chk("midrun_rst_status", {busy, done, pass}, 3'b000);
        chk("midrun_rst_err", err, 0);
        chk("midrun_rst_ff", ff, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", {busy, done, drst}, 3'b001);
        run(0, 1'b1);
        run(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
